// File: rtl/gt_rx_align_monitor.sv
// Word-alignment monitor and auto-realign controller for 8b/10b transceiver RX links.
// Qualifies received words once a run of clean commas is seen, counts faults, and requests transceiver resets until lock.
module gt_rx_align_monitor #(
  parameter int BYTES               = 2,
  parameter int COMMA_LANE          = 0,
  parameter int COMMAS_NEEDED       = 30,
  parameter int FAULT_COUNTER_WIDTH = 10,
  parameter int TIMEOUT_CYCLES      = 65536,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int MAX_ATTEMPTS        = 255,
  localparam int ATTEMPT_WIDTH      = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clearCounters,
  input  logic                           resetDone,
  input  logic [8*BYTES-1:0]             rxData,
  input  logic [BYTES-1:0]               rxCharIsK,
  input  logic [BYTES-1:0]               rxCharIsComma,
  input  logic [BYTES-1:0]               rxNotInTable,
  input  logic [BYTES-1:0]               rxDisparityError,
  output logic                           rxSynchronized,
  output logic [8*BYTES-1:0]             outData,
  output logic [BYTES-1:0]               outCharIsK,
  output logic [BYTES-1:0]               outCharIsComma,
  output logic                           gtResetRequest,
  output logic [2:0]                     state,
  output logic [ATTEMPT_WIDTH-1:0]       attemptCount,
  output logic                           alignFailed,
  output logic [FAULT_COUNTER_WIDTH-1:0] badCharCount,
  output logic [FAULT_COUNTER_WIDTH-1:0] badKCount,
  output logic [FAULT_COUNTER_WIDTH-1:0] disparityCount
);

  localparam int COMMA_CNT_WIDTH = (COMMAS_NEEDED > 1) ? $clog2(COMMAS_NEEDED) : 1;
  localparam int TIMER_SPAN      = (TIMEOUT_CYCLES > RESET_PULSE_CYCLES) ? TIMEOUT_CYCLES : RESET_PULSE_CYCLES;
  localparam int TIMER_WIDTH     = $clog2(TIMER_SPAN + 1);

  localparam logic [COMMA_CNT_WIDTH-1:0]     COMMA_RELOAD  = COMMA_CNT_WIDTH'(COMMAS_NEEDED - 1);
  localparam logic [COMMA_CNT_WIDTH-1:0]     COMMA_ZERO    = COMMA_CNT_WIDTH'(1'b0);
  localparam logic [COMMA_CNT_WIDTH-1:0]     COMMA_ONE     = COMMA_CNT_WIDTH'(1'b1);
  localparam logic [TIMER_WIDTH-1:0]         TIMER_ZERO    = TIMER_WIDTH'(1'b0);
  localparam logic [TIMER_WIDTH-1:0]         TIMER_ONE     = TIMER_WIDTH'(1'b1);
  localparam logic [TIMER_WIDTH-1:0]         TIMEOUT_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0]         PULSE_LAST    = TIMER_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [ATTEMPT_WIDTH-1:0]       ATTEMPT_ZERO  = ATTEMPT_WIDTH'(1'b0);
  localparam logic [ATTEMPT_WIDTH-1:0]       ATTEMPT_ONE   = ATTEMPT_WIDTH'(1'b1);
  localparam logic [ATTEMPT_WIDTH-1:0]       ATTEMPT_MAX   = ATTEMPT_WIDTH'(MAX_ATTEMPTS);
  localparam logic [ATTEMPT_WIDTH-1:0]       ATTEMPT_FULL  = {ATTEMPT_WIDTH{1'b1}};
  localparam logic [FAULT_COUNTER_WIDTH-1:0] FAULT_ZERO    = {FAULT_COUNTER_WIDTH{1'b0}};
  localparam logic [FAULT_COUNTER_WIDTH-1:0] FAULT_ONE     = FAULT_COUNTER_WIDTH'(1'b1);
  localparam logic [FAULT_COUNTER_WIDTH-1:0] FAULT_FULL    = {FAULT_COUNTER_WIDTH{1'b1}};
  localparam logic [BYTES-1:0]               COMMA_MASK    = BYTES'(1'b1) << COMMA_LANE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DONE = 3'd1,
    HUNT      = 3'd2,
    LOCKED    = 3'd3,
    RESET     = 3'd4,
    FAILED    = 3'd5
  } alignStateT;

  alignStateT                  state_r;
  alignStateT                  stateNext_s;
  logic [TIMER_WIDTH-1:0]      timer_r;
  logic [COMMA_CNT_WIDTH-1:0]  commaCount_r;
  logic [BYTES-1:0]            strayK_s;
  logic [7:0]                  commaByte_s;
  logic                        wordErr_s;
  logic                        goodComma_s;

  function automatic logic [FAULT_COUNTER_WIDTH-1:0] satInc(
    input logic [FAULT_COUNTER_WIDTH-1:0] value,
    input logic                           hit
  );
    logic [FAULT_COUNTER_WIDTH-1:0] result;
    if (hit && (value != FAULT_FULL)) begin
      result = value + FAULT_ONE;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // K characters are only legal in the comma lane; anywhere else they mean misframing.
  assign strayK_s    = rxCharIsK & ~COMMA_MASK;
  assign commaByte_s = rxData[8*COMMA_LANE +: 8];
  assign wordErr_s   = (|rxNotInTable) | (|rxDisparityError) | (|strayK_s);
  assign goodComma_s = ~wordErr_s & rxCharIsK[COMMA_LANE] & (commaByte_s == 8'hBC);
  assign state       = state_r;

  // Comma run counter; sync is declared when the counter would underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commaCount_r   <= COMMA_RELOAD;
      rxSynchronized <= 1'b0;
    end else if (wordErr_s) begin
      commaCount_r   <= COMMA_RELOAD;
      rxSynchronized <= 1'b0;
    end else if (!rxSynchronized && goodComma_s) begin
      if (commaCount_r == COMMA_ZERO) begin
        commaCount_r   <= COMMA_RELOAD;
        rxSynchronized <= 1'b1;
      end else begin
        commaCount_r   <= commaCount_r - COMMA_ONE;
      end
    end else begin
      commaCount_r   <= commaCount_r;
      rxSynchronized <= rxSynchronized;
    end
  end

  // Qualified data path: pass a word only when already aligned and the word itself is clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outData        <= {(8*BYTES){1'b0}};
      outCharIsK     <= {BYTES{1'b0}};
      outCharIsComma <= {BYTES{1'b0}};
    end else if (rxSynchronized && !wordErr_s) begin
      outData        <= rxData;
      outCharIsK     <= rxCharIsK;
      outCharIsComma <= rxCharIsComma;
    end else begin
      outData        <= {(8*BYTES){1'b0}};
      outCharIsK     <= {BYTES{1'b0}};
      outCharIsComma <= {BYTES{1'b0}};
    end
  end

  // Saturating fault counters, counted only on an aligned link.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badCharCount   <= FAULT_ZERO;
      badKCount      <= FAULT_ZERO;
      disparityCount <= FAULT_ZERO;
    end else if (clearCounters) begin
      badCharCount   <= FAULT_ZERO;
      badKCount      <= FAULT_ZERO;
      disparityCount <= FAULT_ZERO;
    end else begin
      badCharCount   <= satInc(badCharCount,   rxSynchronized & (|rxNotInTable));
      badKCount      <= satInc(badKCount,      rxSynchronized & (|strayK_s));
      disparityCount <= satInc(disparityCount, rxSynchronized & (|rxDisparityError));
    end
  end

  // Realign controller next-state; dropping enable overrides everything.
  always_comb begin
    stateNext_s = state_r;
    if (enable) begin
      case (state_r)
        IDLE: begin
          stateNext_s = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (resetDone) begin
            stateNext_s = HUNT;
          end else begin
            stateNext_s = WAIT_DONE;
          end
        end
        HUNT: begin
          if (rxSynchronized) begin
            stateNext_s = LOCKED;
          end else if (timer_r == TIMEOUT_LAST) begin
            if (attemptCount == ATTEMPT_MAX) begin
              stateNext_s = FAILED;
            end else begin
              stateNext_s = RESET;
            end
          end else begin
            stateNext_s = HUNT;
          end
        end
        RESET: begin
          if (timer_r == PULSE_LAST) begin
            stateNext_s = WAIT_DONE;
          end else begin
            stateNext_s = RESET;
          end
        end
        LOCKED: begin
          if (rxSynchronized) begin
            stateNext_s = LOCKED;
          end else begin
            stateNext_s = HUNT;
          end
        end
        FAILED: begin
          stateNext_s = FAILED;
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
    end else begin
      stateNext_s = IDLE;
    end
  end

  // Controller registers; one timer serves both the hunt timeout and the reset pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      timer_r        <= TIMER_ZERO;
      attemptCount   <= ATTEMPT_ZERO;
      gtResetRequest <= 1'b0;
      alignFailed    <= 1'b0;
    end else begin
      state_r        <= stateNext_s;
      gtResetRequest <= (stateNext_s == RESET);
      alignFailed    <= (stateNext_s == FAILED);

      if (stateNext_s != state_r) begin
        timer_r <= TIMER_ZERO;
      end else if ((state_r == HUNT) || (state_r == RESET)) begin
        timer_r <= timer_r + TIMER_ONE;
      end else begin
        timer_r <= TIMER_ZERO;
      end

      if (stateNext_s == IDLE) begin
        attemptCount <= ATTEMPT_ZERO;
      end else if ((state_r == LOCKED) && (stateNext_s == HUNT)) begin
        attemptCount <= ATTEMPT_ZERO;
      end else if ((state_r != RESET) && (stateNext_s == RESET) && (attemptCount != ATTEMPT_FULL)) begin
        attemptCount <= attemptCount + ATTEMPT_ONE;
      end else begin
        attemptCount <= attemptCount;
      end
    end
  end

endmodule

// File: tb/tb_gt_rx_align_monitor.sv
// Bench for gt_rx_align_monitor: directed and random words against a comma-run model, plus realign timing checks.
module tb_gt_rx_align_monitor;
  localparam int BYTES      = 4;
  localparam int COMMA_LANE = 1;
  localparam int COMMAS     = 5;
  localparam int FCW        = 3;
  localparam int TIMEOUT    = 64;
  localparam int PULSE      = 16;
  localparam int MAX_ATT    = 2;
  localparam int AW         = 2;
  localparam int FAULT_MAX  = (1 << FCW) - 1;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_HUNT = 3'd2, S_LOCKED = 3'd3, S_RESET = 3'd4, S_FAILED = 3'd5;

  logic clk, reset, enable, clearCounters, resetDone;
  logic [8*BYTES-1:0] rxData;
  logic [BYTES-1:0] rxCharIsK, rxCharIsComma, rxNotInTable, rxDisparityError;
  logic rxSynchronized, gtResetRequest, alignFailed;
  logic [8*BYTES-1:0] outData;
  logic [BYTES-1:0] outCharIsK, outCharIsComma;
  logic [2:0] state;
  logic [AW-1:0] attemptCount;
  logic [FCW-1:0] badCharCount, badKCount, disparityCount;

  gt_rx_align_monitor #(
    .BYTES(BYTES), .COMMA_LANE(COMMA_LANE), .COMMAS_NEEDED(COMMAS), .FAULT_COUNTER_WIDTH(FCW),
    .TIMEOUT_CYCLES(TIMEOUT), .RESET_PULSE_CYCLES(PULSE), .MAX_ATTEMPTS(MAX_ATT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clearCounters(clearCounters), .resetDone(resetDone),
    .rxData(rxData), .rxCharIsK(rxCharIsK), .rxCharIsComma(rxCharIsComma),
    .rxNotInTable(rxNotInTable), .rxDisparityError(rxDisparityError),
    .rxSynchronized(rxSynchronized), .outData(outData), .outCharIsK(outCharIsK),
    .outCharIsComma(outCharIsComma), .gtResetRequest(gtResetRequest), .state(state),
    .attemptCount(attemptCount), .alignFailed(alignFailed), .badCharCount(badCharCount),
    .badKCount(badKCount), .disparityCount(disparityCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: length of the current clean-comma run, link status, fault tallies.
  bit mSync;
  int mRun, mBadChar, mBadK, mDisp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mSync = 1'b0; mRun = 0; mBadChar = 0; mBadK = 0; mDisp = 0;
  endtask

  function automatic int bump(input int v);
    return (v >= FAULT_MAX) ? FAULT_MAX : v + 1;
  endfunction

  task automatic tick();
    bit err, stray, good;
    logic [8*BYTES-1:0] eData;
    logic [BYTES-1:0] eK, eC;
    err = 1'b0; stray = 1'b0;
    for (int l = 0; l < BYTES; l++) begin
      if (rxNotInTable[l] || rxDisparityError[l]) err = 1'b1;
      if (rxCharIsK[l] && l != COMMA_LANE) begin err = 1'b1; stray = 1'b1; end
    end
    good = !err && rxCharIsK[COMMA_LANE] && (rxData[8*COMMA_LANE +: 8] == 8'hBC);
    if (mSync && !err) begin
      eData = rxData; eK = rxCharIsK; eC = rxCharIsComma;
    end else begin
      eData = '0; eK = '0; eC = '0;
    end
    if (clearCounters) begin
      mBadChar = 0; mBadK = 0; mDisp = 0;
    end else if (mSync) begin
      if (|rxNotInTable) mBadChar = bump(mBadChar);
      if (stray) mBadK = bump(mBadK);
      if (|rxDisparityError) mDisp = bump(mDisp);
    end
    if (err) begin
      mSync = 1'b0; mRun = 0;
    end else if (!mSync && good) begin
      mRun++;
      if (mRun == COMMAS) begin mSync = 1'b1; mRun = 0; end
    end
    @(posedge clk); #1;
    check("rxSynchronized", 64'(rxSynchronized), 64'(mSync));
    check("outData", 64'(outData), 64'(eData));
    check("outFlags", 64'({outCharIsK, outCharIsComma}), 64'({eK, eC}));
    check("faultCounters", 64'({badCharCount, badKCount, disparityCount}),
          64'({3'(mBadChar), 3'(mBadK), 3'(mDisp)}));
    clearCounters = 1'b0;
  endtask

  task automatic setData();
    rxData = $urandom; rxCharIsK = '0; rxCharIsComma = 4'($urandom);
    rxNotInTable = '0; rxDisparityError = '0;
  endtask

  task automatic setComma();
    setData();
    rxData[8*COMMA_LANE +: 8] = 8'hBC;
    rxCharIsK[COMMA_LANE] = 1'b1;
    rxCharIsComma = '0;
    rxCharIsComma[COMMA_LANE] = 1'b1;
  endtask

  task automatic waitState(input string tag, input logic [2:0] target, input int budget, output int n);
    bit found;
    found = 1'b0; n = 0;
    while (!found && n < budget) begin
      tick(); n++;
      if (state === target) found = 1'b1;
    end
    check({"reach_", tag}, 64'(found), 64'(1'b1));
  endtask

  task automatic pulseLen(input logic [AW-1:0] expAttempt);
    int n;
    n = 0;
    check("req_high_at_reset", 64'(gtResetRequest), 64'(1'b1));
    check("attempt_on_reset", 64'(attemptCount), 64'(expAttempt));
    while (gtResetRequest === 1'b1 && n < 3 * PULSE) begin tick(); n++; end
    check("pulse_length", 64'(n), 64'(PULSE));
    check("state_after_pulse", 64'(state), 64'(S_WAIT));
    tick();
    check("state_hunt_again", 64'(state), 64'(S_HUNT));
  endtask

  initial begin
    int n, r, lane;
    reset = 1'b0; enable = 1'b0; clearCounters = 1'b0; resetDone = 1'b0;
    rxData = '0; rxCharIsK = '0; rxCharIsComma = '0; rxNotInTable = '0; rxDisparityError = '0;
    modelReset();
    #1 reset = 1'b1;
    #2;
    check("reset_values", 64'({rxSynchronized, outData, outCharIsK, outCharIsComma, gtResetRequest,
                              state, attemptCount, alignFailed, badCharCount, badKCount, disparityCount}), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First lock, then a data word passes one cycle later.
    for (int i = 0; i < COMMAS; i++) begin
      setComma(); tick();
      check("sync_on_nth_comma", 64'(rxSynchronized), 64'(i == COMMAS - 1));
    end
    setData(); rxData = 32'h1234_5678; tick();
    check("first_data_passed", 64'(outData), 64'(32'h1234_5678));

    // Drop sync, clear, then an error one comma short of lock restarts the run.
    setData(); rxNotInTable[3] = 1'b1; tick();
    setData(); clearCounters = 1'b1; tick();
    for (int i = 0; i < COMMAS - 1; i++) begin setComma(); tick(); end
    setData(); rxNotInTable = 4'b0100; tick();
    check("no_sync_after_err", 64'(rxSynchronized), 64'(1'b0));
    check("badchar_unsynced", 64'(badCharCount), 64'(0));
    for (int i = 0; i < COMMAS - 1; i++) begin setComma(); tick(); end
    check("no_sync_after_reload", 64'(rxSynchronized), 64'(1'b0));
    setComma(); tick();
    check("sync_after_full_run", 64'(rxSynchronized), 64'(1'b1));

    // Stray K while locked.
    setComma(); rxCharIsK[0] = 1'b1; tick();
    check("sync_drop_on_k", 64'(rxSynchronized), 64'(1'b0));
    check("badk_one", 64'(badKCount), 64'(1));
    check("err_word_zeroed", 64'(outData), 64'(0));

    // Relock/error cycles drive every counter into saturation.
    for (int j = 0; j < FAULT_MAX + 3; j++) begin
      for (int i = 0; i < COMMAS; i++) begin setComma(); tick(); end
      setData(); rxNotInTable[0] = 1'b1; rxDisparityError[2] = 1'b1; rxCharIsK[3] = 1'b1; tick();
    end
    check("counters_saturated", 64'({badCharCount, badKCount, disparityCount}), 64'(9'h1FF));
    for (int i = 0; i < COMMAS; i++) begin setComma(); tick(); end
    setData(); rxNotInTable[1] = 1'b1; clearCounters = 1'b1; tick();
    check("clear_beats_increment", 64'({badCharCount, badKCount, disparityCount}), 64'(0));

    // Random words against the model.
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        setComma();
      end else if (r < 92) begin
        setData();
        if ($urandom_range(0, 4) == 0) begin
          rxCharIsK[COMMA_LANE] = 1'b1; rxData[8*COMMA_LANE +: 8] = 8'h3C;
        end
      end else begin
        if ($urandom_range(0, 1) == 1) setComma(); else setData();
        lane = $urandom_range(0, BYTES - 1);
        case ($urandom_range(0, 2))
          0: rxNotInTable[lane] = 1'b1;
          1: rxDisparityError[lane] = 1'b1;
          default: rxCharIsK[(lane == COMMA_LANE) ? 3 : lane] = 1'b1;
        endcase
      end
      clearCounters = ($urandom_range(0, 49) == 0);
      tick();
    end
    check("idle_while_disabled", 64'({state, attemptCount}), 64'({S_IDLE, 2'd0}));

    // Realign controller: timeout, reset pulse, lock, loss of lock, exhaustion.
    setData(); rxDisparityError[0] = 1'b1; tick();
    setData();
    enable = 1'b1; resetDone = 1'b1;
    tick(); check("enter_wait_done", 64'(state), 64'(S_WAIT));
    tick(); check("enter_hunt", 64'(state), 64'(S_HUNT));
    waitState("reset1", S_RESET, 3 * TIMEOUT, n);
    check("timeout_gap1", 64'(n), 64'(TIMEOUT));
    pulseLen(2'd1);
    setComma();
    waitState("locked", S_LOCKED, 20, n);
    check("lock_latency", 64'(n), 64'(COMMAS + 1));
    check("attempt_kept_locked", 64'(attemptCount), 64'(1));
    setData(); rxCharIsK[0] = 1'b1; tick();
    setData(); tick();
    check("unlock_to_hunt", 64'({state, attemptCount}), 64'({S_HUNT, 2'd0}));
    waitState("reset2", S_RESET, 3 * TIMEOUT, n);
    check("timeout_gap2", 64'(n), 64'(TIMEOUT));
    pulseLen(2'd1);
    waitState("reset3", S_RESET, 3 * TIMEOUT, n);
    pulseLen(2'd2);
    waitState("failed", S_FAILED, 3 * TIMEOUT, n);
    check("timeout_gap_fail", 64'(n), 64'(TIMEOUT));
    check("failed_flags", 64'({alignFailed, gtResetRequest, attemptCount}), 64'({1'b1, 1'b0, 2'd2}));
    repeat (5) tick();
    check("failed_absorbing", 64'(state), 64'(S_FAILED));
    enable = 1'b0; tick();
    check("disable_from_failed", 64'({state, attemptCount, alignFailed}), 64'({S_IDLE, 2'd0, 1'b0}));

    // Hold in WAIT_DONE, then truncate a reset pulse.
    resetDone = 1'b0; enable = 1'b1; tick();
    repeat (5) tick();
    check("hold_wait_done", 64'(state), 64'(S_WAIT));
    resetDone = 1'b1; tick();
    check("done_to_hunt", 64'(state), 64'(S_HUNT));
    waitState("reset4", S_RESET, 3 * TIMEOUT, n);
    repeat (3) tick();
    check("req_mid_pulse", 64'(gtResetRequest), 64'(1'b1));
    enable = 1'b0; tick();
    check("pulse_truncated", 64'({state, gtResetRequest, attemptCount}), 64'({S_IDLE, 1'b0, 2'd0}));

    // Asynchronous reset while locked, then relock.
    enable = 1'b1; setComma();
    waitState("locked_pre_reset", S_LOCKED, 30, n);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 64'({rxSynchronized, outData, outCharIsK, outCharIsComma, gtResetRequest,
                                     state, attemptCount, alignFailed, badCharCount, badKCount, disparityCount}), 64'(0));
    modelReset();
    @(posedge clk); #1 reset = 1'b0;
    waitState("relock", S_LOCKED, 30, n);
    check("relock_latency", 64'(n), 64'(COMMAS + 1));
    setData(); rxData = 32'hCAFE_F00D; tick();
    check("data_after_relock", 64'(outData), 64'(32'hCAFE_F00D));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
